// File: rtl/cvbs_pkg.sv
// Shared constants, phase encodings and the output clip helper for the
// cvbs_mod4 composite-video modulator.
package cvbs_pkg;

    localparam int BLANK_LV  = 128;
    localparam int SYNC_LV   = 25;
    localparam int BURST_AMP = 44;
    localparam int BURST_PAL = 31;

    typedef enum logic [1:0] {
        PH_U  = 2'd0,
        PH_V  = 2'd1,
        PH_NU = 2'd2,
        PH_NV = 2'd3
    } ph_e;

    // Saturate a signed sum into the unsigned range [0, 2^ow-1].
    function automatic int clip_sum(input int s, input int ow);
        int mx;
        mx = (1 << ow) - 1;
        if (s < 0) return 0;
        if (s > mx) return mx;
        return s;
    endfunction

endpackage

// File: rtl/cvbs_mod4_chroma.sv
// Combinational chroma axis select: burst/PAL V-switch, most-negative
// saturation and per-phase negation of the U/V axes.
module cvbs_mod4_chroma #(
    parameter int CW        = 8,
    parameter int BURST_AMP = cvbs_pkg::BURST_AMP,
    parameter int BURST_PAL = cvbs_pkg::BURST_PAL
) (
    input  cvbs_pkg::ph_e         ph,
    input  logic [CW-1:0]         uu,
    input  logic [CW-1:0]         vv,
    input  logic                  burst,
    input  logic                  blank,
    input  logic                  xsync_n,
    input  logic                  pal,
    input  logic                  line,
    output logic signed [CW:0]    chroma
);
    import cvbs_pkg::*;

    localparam logic signed [CW-1:0] MOST_NEG = {1'b1, {(CW-1){1'b0}}};
    localparam logic signed [CW:0]   POS_MAX  = (CW+1)'(2**(CW-1) - 1);
    localparam logic signed [CW:0]   B_NTSC   = (CW+1)'(BURST_AMP);
    localparam logic signed [CW:0]   B_PAL    = (CW+1)'(BURST_PAL);

    function automatic logic signed [CW:0] sat_ext(input logic signed [CW-1:0] x);
        return (x == MOST_NEG) ? -POS_MAX : (CW+1)'(x);
    endfunction

    logic signed [CW:0] u_ax;
    logic signed [CW:0] v_ax;

    always_comb begin
        u_ax = sat_ext(uu);
        v_ax = sat_ext(vv);
        if (pal && line) v_ax = -v_ax;
        if (burst) begin
            u_ax = pal ? -B_PAL : -B_NTSC;
            v_ax = !pal ? '0 : (line ? -B_PAL : B_PAL);
        end
        case (ph)
            PH_U:    chroma = u_ax;
            PH_V:    chroma = v_ax;
            PH_NU:   chroma = -u_ax;
            default: chroma = -v_ax;
        endcase
        if (!xsync_n || (blank && !burst)) chroma = '0;
    end

endmodule

// File: rtl/cvbs_mod4.sv
// 4fsc composite-video modulator, two-stage pipeline with clipped output.
// PAL line alternation is built only when CVBS_MOD4_PAL_EN is defined.
module cvbs_mod4 #(
    parameter int YW        = 8,
    parameter int CW        = 8,
    parameter int OW        = 9,
    parameter int BLANK_LV  = cvbs_pkg::BLANK_LV,
    parameter int SYNC_LV   = cvbs_pkg::SYNC_LV,
    parameter int BURST_AMP = cvbs_pkg::BURST_AMP,
    parameter int BURST_PAL = cvbs_pkg::BURST_PAL
) (
    input  logic          CK_i,
    input  logic          XAR_i,
    input  logic          CK_EE_i,
    input  logic          XR_i,
    input  logic [YW-1:0] YYs_i,
    input  logic [CW-1:0] UUs_i,
    input  logic [CW-1:0] VVs_i,
    input  logic          BURST_i,
    input  logic          BLANK_i,
    input  logic          XSYNC_i,
    input  logic          PAL_i,
    output logic [OW-1:0] VIDEOs_o,
    output logic [1:0]    PHs_o
);
    import cvbs_pkg::*;

    logic [1:0]           ph;
    logic signed [CW:0]   chroma_sel;
    logic signed [CW:0]   chroma_s1;
    logic signed [OW+1:0] luma_d;
    logic signed [OW+1:0] luma_s1;
    logic signed [OW+1:0] sum;
    logic [OW-1:0]        video_d;
    logic [OW-1:0]        video_q;
    logic                 pal_eff;
    logic                 line_eff;

`ifdef CVBS_MOD4_PAL_EN
    logic xsync_q;
    logic line_q;

    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            xsync_q <= 1'b1;
            line_q  <= 1'b0;
        end else if (CK_EE_i) begin
            xsync_q <= XSYNC_i;
            if (!XR_i)
                line_q <= 1'b0;
            else if (xsync_q && !XSYNC_i)
                line_q <= ~line_q;
        end
    end

    assign pal_eff  = PAL_i;
    assign line_eff = line_q;
`else
    logic unused_pal;
    assign unused_pal = PAL_i;
    assign pal_eff    = 1'b0;
    assign line_eff   = 1'b0;
`endif

    cvbs_mod4_chroma #(
        .CW        (CW),
        .BURST_AMP (BURST_AMP),
        .BURST_PAL (BURST_PAL)
    ) u_chroma (
        .ph      (ph_e'(ph)),
        .uu      (UUs_i),
        .vv      (VVs_i),
        .burst   (BURST_i),
        .blank   (BLANK_i),
        .xsync_n (XSYNC_i),
        .pal     (pal_eff),
        .line    (line_eff),
        .chroma  (chroma_sel)
    );

    always_comb begin
        if (!XSYNC_i)
            luma_d = (OW+2)'(SYNC_LV);
        else if (BLANK_i || BURST_i)
            luma_d = (OW+2)'(BLANK_LV);
        else
            luma_d = (OW+2)'(BLANK_LV) + (OW+2)'(YYs_i);
    end

    // Chroma is sign-extended into the OW+2 bit sum before clipping.
    assign sum     = luma_s1 + (OW+2)'(chroma_s1);
    assign video_d = OW'(clip_sum(int'(sum), OW));

    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            ph        <= 2'd0;
            luma_s1   <= (OW+2)'(BLANK_LV);
            chroma_s1 <= '0;
            video_q   <= OW'(BLANK_LV);
        end else if (CK_EE_i) begin
            if (!XR_i) begin
                ph        <= 2'd0;
                luma_s1   <= (OW+2)'(BLANK_LV);
                chroma_s1 <= '0;
                video_q   <= OW'(BLANK_LV);
            end else begin
                ph        <= ph + 2'd1;
                luma_s1   <= luma_d;
                chroma_s1 <= chroma_sel;
                video_q   <= video_d;
            end
        end
    end

    assign VIDEOs_o = video_q;
    assign PHs_o    = ph;

endmodule

// File: tb/tb_cvbs_mod4.sv
// Scoreboard bench for cvbs_mod4: default instance plus an OW=8 /
// BLANK_LV=10 instance to reach both clip limits.
module tb_cvbs_mod4;

    logic       CK_i = 1'b0;
    logic       XAR_i = 1'b1;
    logic       CK_EE_i, XR_i, BURST_i, BLANK_i, XSYNC_i, PAL_i;
    logic [7:0] YYs_i, UUs_i, VVs_i;
    logic [8:0] video1;
    logic [7:0] video2;
    logic [1:0] ph1, ph2;

    int vectors = 0;
    int miscompares = 0;

    int m_ph, m_line, m_xs_prev;
    int q1[$];
    int q2[$];
    int cur1, cur2;

    always #5 CK_i = ~CK_i;

    cvbs_mod4 u_dut (
        .CK_i(CK_i), .XAR_i(XAR_i), .CK_EE_i(CK_EE_i), .XR_i(XR_i),
        .YYs_i(YYs_i), .UUs_i(UUs_i), .VVs_i(VVs_i),
        .BURST_i(BURST_i), .BLANK_i(BLANK_i), .XSYNC_i(XSYNC_i), .PAL_i(PAL_i),
        .VIDEOs_o(video1), .PHs_o(ph1)
    );

    cvbs_mod4 #(.OW(8), .BLANK_LV(10)) u_dut_clip (
        .CK_i(CK_i), .XAR_i(XAR_i), .CK_EE_i(CK_EE_i), .XR_i(XR_i),
        .YYs_i(YYs_i), .UUs_i(UUs_i), .VVs_i(VVs_i),
        .BURST_i(BURST_i), .BLANK_i(BLANK_i), .XSYNC_i(XSYNC_i), .PAL_i(PAL_i),
        .VIDEOs_o(video2), .PHs_o(ph2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input logic [7:0] y, u, v,
                                 input logic burst, blank, xs, pal,
                                 input int line, ph, ow, blv);
        int us, vs, cu, cv, c, l, s, mx;
        us = int'($signed(u));
        vs = int'($signed(v));
        if (us == -128) us = -127;
        if (vs == -128) vs = -127;
        c = 0;
        if (xs && !(blank && !burst)) begin
            if (burst) begin
                cu = pal ? -31 : -44;
                cv = pal ? (line != 0 ? -31 : 31) : 0;
            end else begin
                cu = us;
                cv = (pal && line != 0) ? -vs : vs;
            end
            case (ph)
                0:       c = cu;
                1:       c = cv;
                2:       c = -cu;
                default: c = -cv;
            endcase
        end
        l = !xs ? 25 : ((blank || burst) ? blv : int'(y) + blv);
        s = l + c;
        mx = (1 << ow) - 1;
        if (s < 0) s = 0;
        if (s > mx) s = mx;
        return s;
    endfunction

    task automatic model_reset();
        q1.delete(); q2.delete();
        q1.push_back(128); q2.push_back(10);
        cur1 = 128; cur2 = 10;
        m_ph = 0; m_line = 0; m_xs_prev = 1;
    endtask

    task automatic do_reset();
        XAR_i = 1'b0;
        #1;
        chk("rst_video", video1, 128);
        chk("rst_video_ow8", video2, 10);
        chk("rst_phase", ph1, 0);
        model_reset();
        #2;
        XAR_i = 1'b1;
    endtask

    task automatic cyc(input logic en, xr, input logic [7:0] y, u, v,
                       input logic burst, blank, xs, pal);
        int e1, e2, x;
        logic pal_eff;
        CK_EE_i = en; XR_i = xr; YYs_i = y; UUs_i = u; VVs_i = v;
        BURST_i = burst; BLANK_i = blank; XSYNC_i = xs; PAL_i = pal;
        pal_eff = 1'b0;
`ifdef CVBS_MOD4_PAL_EN
        pal_eff = pal;
`endif
        e1 = model(y, u, v, burst, blank, xs, pal_eff, m_line, m_ph, 9, 128);
        e2 = model(y, u, v, burst, blank, xs, pal_eff, m_line, m_ph, 8, 10);
        @(posedge CK_i);
        #1;
        if (en) begin
            if (!xr) begin
                q1.delete(); q2.delete();
                q1.push_back(128); q2.push_back(10);
                cur1 = 128; cur2 = 10;
                m_ph = 0; m_line = 0;
                chk("clr_video", video1, 128);
                chk("clr_video_ow8", video2, 10);
            end else begin
                q1.push_back(e1); q2.push_back(e2);
                m_ph = (m_ph + 1) % 4;
`ifdef CVBS_MOD4_PAL_EN
                if (m_xs_prev == 1 && xs == 1'b0) m_line ^= 1;
`endif
                if (q1.size() >= 2) begin
                    x = q1.pop_front(); cur1 = x;
                    chk("video", video1, x);
                end
                if (q2.size() >= 2) begin
                    x = q2.pop_front(); cur2 = x;
                    chk("video_ow8", video2, x);
                end
            end
            m_xs_prev = int'(xs);
        end else begin
            chk("hold_video", video1, cur1);
            chk("hold_video_ow8", video2, cur2);
        end
        chk("phase", ph1, m_ph);
    endtask

    initial begin
        CK_EE_i = 1'b1; XR_i = 1'b1; YYs_i = '0; UUs_i = '0; VVs_i = '0;
        BURST_i = 1'b0; BLANK_i = 1'b0; XSYNC_i = 1'b1; PAL_i = 1'b0;
        #1;
        do_reset();

        // Clear, then active NTSC: expect D0, E0, B0, A0 repeating
        repeat (2) cyc(1, 0, 8'h40, 8'h10, 8'h20, 0, 0, 1, 0);
        repeat (9) cyc(1, 1, 8'h40, 8'h10, 8'h20, 0, 0, 1, 0);

        // NTSC burst, then sync tip
        repeat (5) cyc(1, 1, 8'h40, 8'h10, 8'h20, 1, 1, 1, 0);
        repeat (5) cyc(1, 1, 8'h40, 8'h10, 8'h20, 0, 0, 0, 0);

        // Saturation and both clip limits
        repeat (5) cyc(1, 1, 8'h00, 8'h80, 8'h80, 0, 0, 1, 0);
        repeat (5) cyc(1, 1, 8'hF0, 8'h7F, 8'h7F, 0, 0, 1, 0);

        // Enable gating
        for (int i = 0; i < 10; i++)
            cyc((i % 2) == 0, 1, 8'(8'h20 + i), 8'(8'h08 * i), 8'h30, 0, 0, 1, 0);

        // Clear held off by CK_EE_i=0, then applied
        cyc(0, 0, 8'h40, 8'h10, 8'h20, 0, 0, 1, 0);
        cyc(1, 0, 8'h40, 8'h10, 8'h20, 0, 0, 1, 0);
        repeat (3) cyc(1, 1, 8'h40, 8'h10, 8'h20, 0, 0, 1, 0);

        // Asynchronous reset mid-stream
        do_reset();
        repeat (6) cyc(1, 1, 8'h40, 8'h10, 8'h20, 0, 0, 1, 0);

`ifdef CVBS_MOD4_PAL_EN
        cyc(1, 0, 8'h00, 8'h00, 8'h20, 0, 0, 1, 1);
        cyc(1, 1, 8'h00, 8'h00, 8'h20, 0, 0, 1, 1);
        cyc(1, 1, 8'h00, 8'h00, 8'h20, 0, 0, 0, 1);
        repeat (2) cyc(1, 1, 8'h00, 8'h00, 8'h20, 0, 0, 1, 1);
        repeat (5) cyc(1, 1, 8'h00, 8'h00, 8'h20, 1, 1, 1, 1);
        repeat (5) cyc(1, 1, 8'h00, 8'h00, 8'h20, 0, 0, 1, 1);
        cyc(1, 1, 8'h00, 8'h00, 8'h20, 0, 0, 0, 1);
        repeat (5) cyc(1, 1, 8'h00, 8'h00, 8'h20, 1, 1, 1, 1);
        // Falling sync coinciding with clear: clear wins
        cyc(1, 1, 8'h00, 8'h00, 8'h20, 0, 0, 1, 1);
        cyc(1, 0, 8'h00, 8'h00, 8'h20, 0, 0, 0, 1);
        repeat (5) cyc(1, 1, 8'h00, 8'h00, 8'h20, 1, 1, 1, 1);
        do_reset();
        repeat (5) cyc(1, 1, 8'h00, 8'h00, 8'h20, 1, 1, 1, 1);
`endif

        // Randomised mixed traffic
        for (int i = 0; i < 60; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
                8'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
